// File: rtl/communication_selector_multi.sv
// rtl/communication_selector_multi.sv - per-channel sequenced UART/I2C pin selector
//
// Purpose: routes each of ChannelCount_Gen external pin pairs to either a UART or an
// I2C core. A mode change is sequenced per channel: drain the active protocol until
// it is idle (or a drain timeout expires), tristate both pins for a guard period,
// then adopt the new mode. Channels are fully independent.
// Ports (every vector carries one bit per channel):
//   SysClk_ClkIn, SysRst_RstIn            clock, synchronous active-high reset
//   SelIn_DatIn                           asynchronous mode request (0 UART, 1 I2C)
//   TxScl_DatIn/DatOut, TxSclT_EnaOut     pin A input, output, tristate (1 = Z)
//   RxSda_DatIn/DatOut, RxSdaT_EnaOut     pin B input, output, tristate (1 = Z)
//   Irq_DatOut                            interrupt of the active core, 0 while guarding
//   UartTx/UartRx/UartIrq                 UART core side
//   I2cScl*/I2cSda*/I2cIrq_DatIn          I2C core side
//   ActiveMode_DatOut                     mode currently applied
//   Busy_DatOut                           channel is draining or guarding
//   Timeout_EvtOut                        one-cycle pulse when a drain was forced
module communication_selector_multi #(
  parameter int ChannelCount_Gen = 4,
  parameter int IdleCycles_Gen   = 16,
  parameter int GuardCycles_Gen  = 8,
  parameter int DrainTimeout_Gen = 100000
) (
  input  logic                        SysClk_ClkIn,
  input  logic                        SysRst_RstIn,
  input  logic [ChannelCount_Gen-1:0] SelIn_DatIn,
  input  logic [ChannelCount_Gen-1:0] TxScl_DatIn,
  output logic [ChannelCount_Gen-1:0] TxScl_DatOut,
  output logic [ChannelCount_Gen-1:0] TxSclT_EnaOut,
  input  logic [ChannelCount_Gen-1:0] RxSda_DatIn,
  output logic [ChannelCount_Gen-1:0] RxSda_DatOut,
  output logic [ChannelCount_Gen-1:0] RxSdaT_EnaOut,
  output logic [ChannelCount_Gen-1:0] Irq_DatOut,
  input  logic [ChannelCount_Gen-1:0] UartTx_DatIn,
  output logic [ChannelCount_Gen-1:0] UartRx_DatOut,
  input  logic [ChannelCount_Gen-1:0] UartIrq_DatIn,
  output logic [ChannelCount_Gen-1:0] I2cSclIn_DatOut,
  input  logic [ChannelCount_Gen-1:0] I2cSclOut_DatIn,
  input  logic [ChannelCount_Gen-1:0] I2cSclT_EnaIn,
  output logic [ChannelCount_Gen-1:0] I2cSdaIn_DatOut,
  input  logic [ChannelCount_Gen-1:0] I2cSdaOut_DatIn,
  input  logic [ChannelCount_Gen-1:0] I2cSdaT_EnaIn,
  input  logic [ChannelCount_Gen-1:0] I2cIrq_DatIn,
  output logic [ChannelCount_Gen-1:0] ActiveMode_DatOut,
  output logic [ChannelCount_Gen-1:0] Busy_DatOut,
  output logic [ChannelCount_Gen-1:0] Timeout_EvtOut
);

  localparam int IW = $clog2(IdleCycles_Gen + 1);
  localparam int TW = $clog2(DrainTimeout_Gen + 1);
  localparam int GW = $clog2(GuardCycles_Gen + 1);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(IdleCycles_Gen);
  localparam logic [TW-1:0] DRAIN_MAX  = TW'(DrainTimeout_Gen);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GuardCycles_Gen - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GUARD = 2'd2
  } state_e;

  for (genvar g = 0; g < ChannelCount_Gen; g++) begin : g_ch
    state_e          state_q, state_d;
    logic            sel_meta_q, sel_meta_d;
    logic            sel_q, sel_d;
    logic            sel_prev_q, sel_prev_d;
    logic            active_q, active_d;
    logic            timeout_q, timeout_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [TW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [GW-1:0]   guard_cnt_q, guard_cnt_d;
    logic [IW-1:0]   idle_inc;
    logic [TW-1:0]   drain_inc;
    logic            line_idle;
    logic            tx_o, tx_t, rx_o, rx_t, urx, scl_i, sda_i, irq_o;

    always_comb begin
      sel_meta_d  = SelIn_DatIn[g];
      sel_d       = sel_meta_q;
      sel_prev_d  = sel_q;
      state_d     = state_q;
      active_d    = active_q;
      timeout_d   = 1'b0;
      idle_cnt_d  = idle_cnt_q;
      drain_cnt_d = drain_cnt_q;
      guard_cnt_d = guard_cnt_q;
      // Idle is judged on the protocol currently applied, not the requested one.
      line_idle   = active_q ? (I2cSclT_EnaIn[g] & I2cSdaT_EnaIn[g]) : UartTx_DatIn[g];
      idle_inc    = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + IW'(1);
      drain_inc   = (drain_cnt_q == DRAIN_MAX) ? drain_cnt_q : drain_cnt_q + TW'(1);
      case (state_q)
        ST_RUN: begin
          if (sel_q != active_q) begin
            state_d     = ST_DRAIN;
            idle_cnt_d  = '0;
            drain_cnt_d = '0;
          end
        end
        ST_DRAIN: begin
          idle_cnt_d  = line_idle ? idle_inc : '0;
          drain_cnt_d = drain_inc;
          // A withdrawn request wins over both exit conditions in the same cycle.
          if (sel_q == active_q) begin
            state_d = ST_RUN;
          end else if (line_idle && (idle_inc == IDLE_MAX)) begin
            state_d     = ST_GUARD;
            guard_cnt_d = '0;
          end else if (drain_inc == DRAIN_MAX) begin
            state_d     = ST_GUARD;
            guard_cnt_d = '0;
            timeout_d   = 1'b1;
          end
        end
        default: begin
          // Any movement of the request restarts the guard so the final mode
          // always gets a full quiet period in front of it.
          if (sel_q != sel_prev_q) begin
            guard_cnt_d = '0;
          end else if (guard_cnt_q == GUARD_LAST) begin
            state_d     = ST_RUN;
            active_d    = sel_q;
            guard_cnt_d = '0;
          end else begin
            guard_cnt_d = guard_cnt_q + GW'(1);
          end
        end
      endcase
    end

    always_ff @(posedge SysClk_ClkIn) begin
      if (SysRst_RstIn) begin
        state_q     <= ST_GUARD;
        sel_meta_q  <= 1'b0;
        sel_q       <= 1'b0;
        sel_prev_q  <= 1'b0;
        active_q    <= 1'b0;
        timeout_q   <= 1'b0;
        idle_cnt_q  <= '0;
        drain_cnt_q <= '0;
        guard_cnt_q <= '0;
      end else begin
        state_q     <= state_d;
        sel_meta_q  <= sel_meta_d;
        sel_q       <= sel_d;
        sel_prev_q  <= sel_prev_d;
        active_q    <= active_d;
        timeout_q   <= timeout_d;
        idle_cnt_q  <= idle_cnt_d;
        drain_cnt_q <= drain_cnt_d;
        guard_cnt_q <= guard_cnt_d;
      end
    end

    // Pin routing: RUN and DRAIN share the live routing; GUARD parks both pins in Z
    // and feeds idle levels to both cores.
    always_comb begin
      tx_o  = 1'b0;
      tx_t  = 1'b1;
      rx_o  = 1'b0;
      rx_t  = 1'b1;
      urx   = 1'b1;
      scl_i = 1'b1;
      sda_i = 1'b1;
      irq_o = 1'b0;
      if (state_q != ST_GUARD) begin
        if (active_q) begin
          tx_o  = I2cSclOut_DatIn[g];
          tx_t  = I2cSclT_EnaIn[g];
          rx_o  = I2cSdaOut_DatIn[g];
          rx_t  = I2cSdaT_EnaIn[g];
          scl_i = TxScl_DatIn[g];
          sda_i = RxSda_DatIn[g];
          irq_o = I2cIrq_DatIn[g];
        end else begin
          tx_o  = UartTx_DatIn[g];
          tx_t  = 1'b0;
          urx   = RxSda_DatIn[g];
          irq_o = UartIrq_DatIn[g];
        end
      end
    end

    assign TxScl_DatOut[g]      = tx_o;
    assign TxSclT_EnaOut[g]     = tx_t;
    assign RxSda_DatOut[g]      = rx_o;
    assign RxSdaT_EnaOut[g]     = rx_t;
    assign UartRx_DatOut[g]     = urx;
    assign I2cSclIn_DatOut[g]   = scl_i;
    assign I2cSdaIn_DatOut[g]   = sda_i;
    assign Irq_DatOut[g]        = irq_o;
    assign ActiveMode_DatOut[g] = active_q;
    assign Busy_DatOut[g]       = (state_q != ST_RUN);
    assign Timeout_EvtOut[g]    = timeout_q;
  end

endmodule

// File: tb/tb_communication_selector_multi.sv
// tb/tb_communication_selector_multi.sv - scoreboard bench for communication_selector_multi
module tb_communication_selector_multi;
  localparam int N     = 4;
  localparam int IDLE  = 16;
  localparam int GUARD = 8;
  localparam int TMO   = 200;

  typedef struct {
    int req;
    int drain;
    int guard;
    int tmo;
    int mode;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] sel_in, txscl_in, rxsda_in, uart_tx, uart_irq;
  logic [N-1:0] scl_out, scl_t, sda_out, sda_t, i2c_irq, held;
  logic [N-1:0] txscl_out, txscl_t, rxsda_out, rxsda_t, irq_o, uart_rx;
  logic [N-1:0] scl_in_o, sda_in_o, active, busy, tmo_evt;

  exp_t exp_q [N][$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   stim_mode [N];

  communication_selector_multi #(
    .ChannelCount_Gen(N), .IdleCycles_Gen(IDLE),
    .GuardCycles_Gen(GUARD), .DrainTimeout_Gen(TMO)
  ) dut (
    .SysClk_ClkIn(clk), .SysRst_RstIn(rst), .SelIn_DatIn(sel_in),
    .TxScl_DatIn(txscl_in), .TxScl_DatOut(txscl_out), .TxSclT_EnaOut(txscl_t),
    .RxSda_DatIn(rxsda_in), .RxSda_DatOut(rxsda_out), .RxSdaT_EnaOut(rxsda_t),
    .Irq_DatOut(irq_o), .UartTx_DatIn(uart_tx), .UartRx_DatOut(uart_rx),
    .UartIrq_DatIn(uart_irq), .I2cSclIn_DatOut(scl_in_o), .I2cSclOut_DatIn(scl_out),
    .I2cSclT_EnaIn(scl_t), .I2cSdaIn_DatOut(sda_in_o), .I2cSdaOut_DatIn(sda_out),
    .I2cSdaT_EnaIn(sda_t), .I2cIrq_DatIn(i2c_irq), .ActiveMode_DatOut(active),
    .Busy_DatOut(busy), .Timeout_EvtOut(tmo_evt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int c, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s ch%0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask

  // Classic selector truth table: {txo, txt, rxo, rxt, uart_rx, scl_in, sda_in, irq}
  function automatic logic [7:0] route(input bit m, input int c);
    if (m) return {scl_out[c], scl_t[c], sda_out[c], sda_t[c], 1'b1,
                   txscl_in[c], rxsda_in[c], i2c_irq[c]};
    return {uart_tx[c], 1'b0, 1'b0, 1'b1, rxsda_in[c], 1'b1, 1'b1, uart_irq[c]};
  endfunction

  // Monitor: classifies every busy cycle as drain or guard from the pin view and
  // pops the expected switch outcome when Busy falls.
  initial begin
    bit   busy_prev [N];
    bit   model_mode [N];
    int   d_cnt [N];
    int   g_cnt [N];
    int   t_cnt [N];
    int   rise_cyc [N];
    exp_t e;
    logic gd;
    for (int c = 0; c < N; c++) begin
      busy_prev[c] = 1'b0; model_mode[c] = 1'b0;
      d_cnt[c] = 0; g_cnt[c] = 0; t_cnt[c] = 0; rise_cyc[c] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < N; c++) begin
        if (rst) begin
          chk("reset_state", c,
              int'({txscl_t[c], rxsda_t[c], txscl_out[c], rxsda_out[c], irq_o[c],
                    active[c], busy[c], tmo_evt[c]}), int'(8'b1100_0010));
          d_cnt[c] = 0; g_cnt[c] = 0; t_cnt[c] = 0;
        end
        if (busy[c] && !busy_prev[c]) rise_cyc[c] = cyc;
        if (busy[c]) begin
          gd = txscl_t[c] & rxsda_t[c] & ~txscl_out[c] & ~rxsda_out[c] & ~irq_o[c]
               & uart_rx[c] & scl_in_o[c] & sda_in_o[c];
          if (gd) g_cnt[c]++; else d_cnt[c]++;
          if (tmo_evt[c]) t_cnt[c]++;
        end
        if (exp_q[c].size() == 0 && (cyc % 4) == 0) chk("busy_without_request", c, int'(busy[c]), 0);
        if (!busy[c] && busy_prev[c]) begin
          chk("switch_expected", c, int'(exp_q[c].size() > 0), 1);
          if (exp_q[c].size() > 0) begin
            e = exp_q[c].pop_front();
            chk("drain_cycles", c, d_cnt[c], e.drain);
            chk("guard_cycles", c, g_cnt[c], e.guard);
            chk("timeout_pulses", c, t_cnt[c], e.tmo);
            chk("active_mode", c, int'(active[c]), e.mode);
            if (e.req >= 0) chk("busy_latency", c, rise_cyc[c] - e.req, 3);
            model_mode[c] = (e.mode != 0);
          end
          d_cnt[c] = 0; g_cnt[c] = 0; t_cnt[c] = 0;
        end
        if (!busy[c] && (cyc % 4) == 0)
          chk("routing", c,
              int'({txscl_out[c], txscl_t[c], rxsda_out[c], rxsda_t[c], uart_rx[c],
                    scl_in_o[c], sda_in_o[c], irq_o[c]}), int'(route(model_mode[c], c)));
        busy_prev[c] = busy[c];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    uart_tx  = (uart_tx  & held) | (N'($urandom()) & ~held);
    uart_irq = (uart_irq & held) | (N'($urandom()) & ~held);
    scl_out  = (scl_out  & held) | (N'($urandom()) & ~held);
    scl_t    = (scl_t    & held) | (N'($urandom()) & ~held);
    sda_out  = (sda_out  & held) | (N'($urandom()) & ~held);
    sda_t    = (sda_t    & held) | (N'($urandom()) & ~held);
    i2c_irq  = (i2c_irq  & held) | (N'($urandom()) & ~held);
    txscl_in = (txscl_in & held) | (N'($urandom()) & ~held);
    rxsda_in = (rxsda_in & held) | (N'($urandom()) & ~held);
  endtask

  task automatic hold_chan(input int c);
    held[c] = 1'b1; txscl_in[c] = 1'b0; rxsda_in[c] = 1'b0;
    uart_irq[c] = 1'b1; i2c_irq[c] = 1'b1; scl_out[c] = 1'b0; sda_out[c] = 1'b0;
    scl_t[c] = 1'b1; sda_t[c] = 1'b1; uart_tx[c] = 1'b1;
  endtask

  task automatic set_line(input int c, input bit m, input bit idle);
    if (m) begin scl_t[c] = 1'b1; sda_t[c] = idle; end
    else uart_tx[c] = idle;
  endtask

  // k >= 0: line busy for k drain cycles, then idle; k < 0: never idle (forced switch)
  task automatic switch_txn(input int c, input int k);
    bit cur;
    cur = stim_mode[c];
    hold_chan(c);
    set_line(c, cur, 1'b0);
    exp_q[c].push_back('{cyc, (k < 0) ? TMO : k + IDLE, GUARD, int'(k < 0), int'(!cur)});
    sel_in[c] = !cur;
    repeat (3) step();
    if (k >= 0) begin
      repeat (k) step();
      set_line(c, cur, 1'b1);
      repeat (IDLE + GUARD + 6) step();
    end else begin
      repeat (TMO + GUARD + 6) step();
    end
    stim_mode[c] = !cur;
    held[c] = 1'b0;
  endtask

  task automatic abort_txn(input int c, input int h);
    bit cur;
    cur = stim_mode[c];
    hold_chan(c);
    set_line(c, cur, 1'b1);
    exp_q[c].push_back('{cyc, h, 0, 0, int'(cur)});
    sel_in[c] = !cur;
    repeat (h) step();
    sel_in[c] = cur;
    repeat (h + 8) step();
    held[c] = 1'b0;
  endtask

  task automatic reset_all();
    sel_in = '0;
    held = '0;
    for (int c = 0; c < N; c++) begin
      exp_q[c].delete();
      exp_q[c].push_back('{-1, 0, GUARD, 0, 0});
      stim_mode[c] = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (GUARD + 6) step();
  endtask

  initial begin
    int c, r;
    rst = 1'b1; sel_in = '0; held = '0;
    uart_tx = '1; uart_irq = '0; scl_out = '0; scl_t = '1; sda_out = '0; sda_t = '1;
    i2c_irq = '0; txscl_in = '0; rxsda_in = '0;
    for (int i = 0; i < N; i++) begin
      stim_mode[i] = 1'b0;
      exp_q[i].push_back('{-1, 0, GUARD, 0, 0});
    end
    repeat (2) step();
    rst = 1'b0;
    repeat (GUARD + 6) step();

    switch_txn(0, 0);
    switch_txn(0, -1);
    abort_txn(1, 5);
    switch_txn(2, 7);
    switch_txn(2, 0);

    for (int i = 0; i < 24; i++) begin
      c = $urandom_range(0, N - 1);
      r = $urandom_range(0, 5);
      if (r == 0) switch_txn(c, -1);
      else if (r == 1) abort_txn(c, $urandom_range(1, IDLE - 1));
      else switch_txn(c, $urandom_range(0, 20));
    end

    if (!stim_mode[3]) switch_txn(3, 0);
    hold_chan(3);
    set_line(3, 1'b1, 1'b1);
    exp_q[3].push_back('{cyc, IDLE, GUARD, 0, 0});
    sel_in[3] = 1'b0;
    repeat (3 + IDLE + 2) step();
    reset_all();

    switch_txn(1, 0);
    repeat (8) step();
    for (int i = 0; i < N; i++) begin
      chk("queue_empty_at_end", i, exp_q[i].size(), 0);
      chk("idle_at_end", i, int'(busy[i]), 0);
      chk("final_mode", i, int'(active[i]), int'(stim_mode[i]));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
